// File: rtl/mem_arb_pkg.sv
// Shared constants for the I/D memory arbiter: FSM state codes, requester
// IDs and the legal range of the memory read latency.
package mem_arb_pkg;

    // FSM state codes
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Requester IDs; also the bit index of each side in the grant vector
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Read latency range supported by the 2-bit latency counter
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int LAT_CNT_W  = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker. A lone requester always wins; on a tie the
// side that did not win last time is chosen. Output is one-hot or zero.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // Pick the winner: pass a single request through, alternate on ties
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_i == REQ_I) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between the instruction fetch port (I) and
// the load/store port (D). One access at a time: stores complete at grant,
// loads park the arbiter in WAIT until the fixed read latency has elapsed,
// then the owner gets a one-cycle rvalid pulse with the memory data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 7,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_en,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic [DW-1:0]   m_rdata
);

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("mem_arbiter: RD_LAT must be in 1..4");
    end

    // Counter reload value: the counter reaches zero in the rvalid cycle
    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LAT - 1);

    logic [0:0]           state_q, state_d;
    logic                 last_q, last_d;
    logic                 owner_q, owner_d;
    logic [LAT_CNT_W-1:0] lat_q, lat_d;
    logic [1:0]           arb_gnt;
    logic                 can_gnt;
    logic                 rd_done;

    rr_arb2 u_rr_arb2 (
        .req_i  ({d_req, i_req}),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    // Grants, memory strobe/muxes and read-return pulses; all held low in reset
    always_comb begin
        can_gnt  = !rst && (state_q == ST_IDLE);
        i_gnt    = can_gnt && arb_gnt[REQ_I];
        d_gnt    = can_gnt && arb_gnt[REQ_D];
        m_en     = i_gnt || d_gnt;
        m_we     = d_gnt && d_we;
        m_addr   = d_gnt ? d_addr : i_addr;
        m_wdata  = d_wdata;
        m_be     = d_gnt ? d_be : '1;
        rd_done  = !rst && (state_q == ST_WAIT) && (lat_q == '0);
        i_rvalid = rd_done && (owner_q == REQ_I);
        d_rvalid = rd_done && (owner_q == REQ_D);
    end

    // Read data is routed straight through; qualified by the rvalid pulses
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // Next-state: record the winner, start a read wait, or count down the latency
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        lat_d   = lat_q;
        if (state_q == ST_IDLE) begin
            if (m_en) begin
                last_d = d_gnt ? REQ_D : REQ_I;
                if (!m_we) begin
                    owner_d = d_gnt ? REQ_D : REQ_I;
                    lat_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
            end
        end else begin
            if (lat_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                lat_d = lat_q - 1'b1;
            end
        end
    end

    // State registers; reset drops any read in flight and lets I win the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= REQ_D;
            owner_q <= REQ_I;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (read latency 1 and 3), each with a
// memory macro model, a transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, and random traffic.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk1(input int lat, input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL lat%0d %s: got %b expected %b at %0t", lat, name, act, exp, $time);
        end
    endtask

    task automatic chk32(input int lat, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL lat%0d %s: got %h expected %h at %0t", lat, name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pre(input int a);
        if (a == 5) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(a) * 32'h0001_0203;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        rst;
        logic        preload;
        logic        i_req, i_gnt, i_rvalid;
        logic [6:0]  i_addr;
        logic [31:0] i_rdata;
        logic        d_req, d_we, d_gnt, d_rvalid;
        logic [6:0]  d_addr;
        logic [31:0] d_wdata, d_rdata;
        logic [3:0]  d_be;
        logic        m_en, m_we;
        logic [6:0]  m_addr;
        logic [31:0] m_wdata, m_rdata;
        logic [3:0]  m_be;
        bit          done = 1'b0;

        mem_arbiter #(.AW(7), .DW(32), .RD_LAT(LAT)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .i_req    (i_req),
            .i_addr   (i_addr),
            .i_gnt    (i_gnt),
            .i_rvalid (i_rvalid),
            .i_rdata  (i_rdata),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_be     (d_be),
            .d_gnt    (d_gnt),
            .d_rvalid (d_rvalid),
            .d_rdata  (d_rdata),
            .m_en     (m_en),
            .m_we     (m_we),
            .m_addr   (m_addr),
            .m_wdata  (m_wdata),
            .m_be     (m_be),
            .m_rdata  (m_rdata)
        );

        // Memory macro: byte-enabled writes, read data LAT cycles after the strobe
        logic [31:0]    mem [128];
        logic [LAT-1:0] pv;
        logic [6:0]     pa [LAT];
        always @(posedge clk) begin
            if (preload) begin
                for (int a = 0; a < 128; a++) mem[a] <= pre(a);
            end else if (m_en && m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
            end
            pv[0] <= m_en && !m_we;
            pa[0] <= m_addr;
            for (int k = 1; k < LAT; k++) begin
                pv[k] <= pv[k-1];
                pa[k] <= pa[k-1];
            end
        end
        assign m_rdata = pv[LAT-1] ? mem[pa[LAT-1]] : 32'h0BAD_F00D;

        // Reference model: a read issued in cycle c returns in cycle c+LAT and
        // blocks all grants until then; ties go to the side not granted last.
        bit          busy = 1'b0;
        int          due = 0;
        bit          owner = 1'b0;
        bit          last = 1'b1;
        int          cyc = 0;
        logic [31:0] exp_data = '0;
        logic [31:0] exp_mem [128];
        always @(negedge clk) begin
            bit         e_ig, e_dg, e_en, e_we, e_irv, e_drv, win;
            logic [6:0] e_addr;
            logic [3:0] e_be;
            e_ig = 0; e_dg = 0; e_en = 0; e_we = 0; e_irv = 0; e_drv = 0; win = 0;
            e_addr = '0; e_be = '0;
            if (preload) for (int a = 0; a < 128; a++) exp_mem[a] = pre(a);
            if (rst) begin
                busy = 0;
                last = 1;
            end else if (busy) begin
                if (cyc == due) begin
                    e_irv = (owner == 0);
                    e_drv = (owner == 1);
                    busy  = 0;
                end
            end else if (i_req || d_req) begin
                win    = (i_req && d_req) ? !last : d_req;
                e_ig   = !win;
                e_dg   = win;
                e_en   = 1;
                e_we   = win && d_we;
                e_addr = win ? d_addr : i_addr;
                e_be   = win ? d_be : 4'hF;
                last   = win;
                if (e_we) begin
                    for (int b = 0; b < 4; b++)
                        if (e_be[b]) exp_mem[e_addr][8*b +: 8] = d_wdata[8*b +: 8];
                end else begin
                    busy     = 1;
                    due      = cyc + LAT;
                    owner    = win;
                    exp_data = exp_mem[e_addr];
                end
            end
            chk1(LAT, "i_gnt", i_gnt, e_ig);
            chk1(LAT, "d_gnt", d_gnt, e_dg);
            chk1(LAT, "m_en", m_en, e_en);
            chk1(LAT, "i_rvalid", i_rvalid, e_irv);
            chk1(LAT, "d_rvalid", d_rvalid, e_drv);
            if (e_en || rst) chk1(LAT, "m_we", m_we, e_we);
            if (e_en) begin
                chk32(LAT, "m_addr", 32'(m_addr), 32'(e_addr));
                chk32(LAT, "m_be", 32'(m_be), 32'(e_be));
                if (e_we) chk32(LAT, "m_wdata", m_wdata, d_wdata);
            end
            if (e_irv) chk32(LAT, "i_rdata", i_rdata, exp_data);
            if (e_drv) chk32(LAT, "d_rdata", d_rdata, exp_data);
            cyc++;
        end

        // Directed scenarios, then random traffic honouring hold-until-grant
        initial begin
            logic        gi, gd;
            int          gc[8];
            bit          gw[8];
            int          ng, rv_at, ig_at;
            rst = 1; preload = 1;
            i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
            repeat (3) @(posedge clk);
            #1 rst = 0; preload = 0;
            if (LAT == 1) begin
                // single fetch of address 5
                i_req = 1; i_addr = 7'd5;
                @(negedge clk);
                chk1(LAT, "t1_i_gnt", i_gnt, 1'b1);
                chk1(LAT, "t1_m_en", m_en, 1'b1);
                @(posedge clk); #1 i_req = 0;
                @(negedge clk);
                chk1(LAT, "t1_i_rvalid", i_rvalid, 1'b1);
                chk32(LAT, "t1_i_rdata", i_rdata, 32'hDEADBEEF);
                chk1(LAT, "t1_d_rvalid", d_rvalid, 1'b0);
                // both sides requesting continuously from reset
                @(posedge clk); #1 rst = 1;
                i_req = 1; i_addr = 7'd3; d_req = 1; d_we = 0; d_addr = 7'd9;
                @(posedge clk); #1 rst = 0;
                ng = 0;
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    if ((i_gnt || d_gnt) && ng < 8) begin
                        gc[ng] = k; gw[ng] = d_gnt; ng++;
                    end
                end
                chk32(LAT, "t2_ngnt", 32'(ng), 32'd4);
                for (int k = 0; k < 4; k++) begin
                    chk1(LAT, "t2_order", gw[k], 1'(k % 2));
                    chk32(LAT, "t2_cycle", 32'(gc[k]), 32'(2 * k));
                end
                @(posedge clk); #1 i_req = 0; d_req = 0;
                repeat (3) @(posedge clk);
                // three back-to-back stores
                #1 d_req = 1; d_we = 1; d_be = 4'b0011;
                for (int k = 1; k <= 3; k++) begin
                    d_addr = 7'(k); d_wdata = $urandom;
                    @(negedge clk);
                    chk1(LAT, "t3_d_gnt", d_gnt, 1'b1);
                    chk1(LAT, "t3_m_we", m_we, 1'b1);
                    chk32(LAT, "t3_m_be", 32'(m_be), 32'h3);
                    @(posedge clk); #1;
                end
                d_req = 0; d_we = 0;
                @(negedge clk);
                chk1(LAT, "t3_m_en_after", m_en, 1'b0);
                chk1(LAT, "t3_no_d_rvalid", d_rvalid, 1'b0);
                // d request pulsed while I owns the wait
                @(posedge clk); #1 i_req = 1; i_addr = 7'd20;
                @(negedge clk);
                chk1(LAT, "t6_i_gnt", i_gnt, 1'b1);
                @(posedge clk); #1 i_req = 0; d_req = 1; d_we = 0; d_addr = 7'd30;
                @(negedge clk);
                chk1(LAT, "t6_d_gnt_wait", d_gnt, 1'b0);
                chk1(LAT, "t6_m_en_wait", m_en, 1'b0);
                @(posedge clk); #1 d_req = 0;
                @(negedge clk);
                chk1(LAT, "t6_m_en_after", m_en, 1'b0);
                @(posedge clk); #1;
            end else begin
                // load at address 7 with I arriving during the wait
                d_req = 1; d_we = 0; d_addr = 7'd7;
                @(negedge clk);
                chk1(LAT, "t4_d_gnt", d_gnt, 1'b1);
                @(posedge clk); #1 d_req = 0; i_req = 1; i_addr = 7'd11;
                rv_at = -1; ig_at = -1;
                for (int n = 1; n <= 6; n++) begin
                    @(negedge clk);
                    if (d_rvalid && rv_at < 0) begin
                        rv_at = n;
                        chk32(LAT, "t4_d_rdata", d_rdata, pre(7));
                    end
                    if (i_gnt && ig_at < 0) ig_at = n;
                    @(posedge clk); #1;
                    if (ig_at > 0) i_req = 0;
                end
                chk32(LAT, "t4_rvalid_lat", 32'(rv_at), 32'd3);
                chk32(LAT, "t4_i_gnt_cycle", 32'(ig_at), 32'd4);
                repeat (4) @(posedge clk);
                // reset one cycle into a load's wait
                #1 d_req = 1; d_addr = 7'd7;
                @(negedge clk);
                chk1(LAT, "t5_d_gnt", d_gnt, 1'b1);
                @(posedge clk); #1 d_req = 0;
                @(posedge clk); #1 rst = 1;
                i_req = 1; i_addr = 7'd2; d_req = 1; d_we = 0; d_addr = 7'd4;
                @(negedge clk);
                chk1(LAT, "t5_rvalid_in_rst", d_rvalid, 1'b0);
                @(posedge clk); #1 rst = 0;
                @(negedge clk);
                chk1(LAT, "t5_tie_i_first", i_gnt, 1'b1);
                chk1(LAT, "t5_tie_no_d", d_gnt, 1'b0);
                @(posedge clk); #1 i_req = 0; d_req = 0;
                for (int n = 0; n < 4; n++) begin
                    @(negedge clk);
                    chk1(LAT, "t5_no_d_rvalid", d_rvalid, 1'b0);
                end
                @(posedge clk); #1;
            end
            // random traffic
            for (int c = 0; c < 800; c++) begin
                @(negedge clk);
                gi = i_gnt; gd = d_gnt;
                @(posedge clk); #1;
                if (gi || !i_req) begin
                    i_req  = ($urandom_range(0, 2) != 0);
                    i_addr = 7'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    i_req = 0;
                end
                if (gd || !d_req) begin
                    d_req   = ($urandom_range(0, 2) != 0);
                    d_we    = 1'($urandom);
                    d_addr  = 7'($urandom);
                    d_wdata = $urandom;
                    d_be    = 4'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    d_req = 0;
                end
                rst = ($urandom_range(0, 199) == 0);
            end
            i_req = 0; d_req = 0; rst = 0;
            repeat (5) @(posedge clk);
            done = 1'b1;
        end
    end

    initial begin
        fork
            wait (g_inst[0].done && g_inst[1].done);
            #200000;
        join_any
        if (!(g_inst[0].done && g_inst[1].done)) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: scenarios finished %0d/%0d, required 2/2",
                     int'(g_inst[0].done) + int'(g_inst[1].done), 2);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
